instr_encoder_loader: RTL and testbench
=======================================

INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-002 The block SHALL provide these ports, one per line as name, direction, width, meaning:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load session.
- base_addr  in  32  byte address of the first word, sampled on start.
- len  in  8  number of words in the session, sampled on start.
- in_valid  in  1  instruction fields are valid.
- in_ready  out  1  block accepts fields this cycle.
- fmt  in  2  instruction format: 00 R, 01 I, 10 S, 11 B.
- opcode  in  7  instruction bits [6:0].
- rd, rs1, rs2  in  5 each  register indices.
- func3  in  3.
- func7  in  7  used for R format only.
- imm  in  32  sign-extended immediate (byte offset for B).
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  32  write byte address.
- mem_wdata  out  32  encoded instruction word.
- busy  out  1  session in progress.
- done  out  1  one-cycle session-complete pulse.
- err  out  1  sticky immediate-range error.
- word_cnt  out  8  words written in the current session.

Function
REQ-003 The state machine SHALL have three states: IDLE, LOAD and DONE.
REQ-004 IDLE SHALL go to LOAD when start=1 and len!=0, latching base_addr and len and clearing word_cnt and err.
REQ-005 IDLE SHALL go to DONE when start=1 and len=0; no write occurs.
REQ-006 LOAD SHALL go to DONE on the edge that accepts the len-th word.
REQ-007 DONE SHALL go to IDLE unconditionally after one cycle.
REQ-008 start SHALL be ignored in LOAD and DONE.
REQ-009 in_ready SHALL be 1 only in LOAD; a word is accepted on a rising edge with in_valid=1 and in_ready=1.
REQ-010 busy SHALL be 1 in LOAD and DONE; done SHALL be 1 only in DONE.
REQ-011 Output latency SHALL be 1 cycle: a word accepted at edge k drives mem_we=1 with registered mem_addr and mem_wdata during the cycle after edge k.
REQ-012 mem_we SHALL be 0 in every cycle that follows an edge with no accept.
REQ-013 The first word SHALL be written at the latched base_addr; each later word SHALL be written at the previous mem_addr+4, wrapping modulo 2^32.
REQ-014 word_cnt SHALL increment on each accept; the last word's mem_we SHALL coincide with done=1.
REQ-015 R-format encoding SHALL be {func7, rs2, rs1, func3, rd, opcode}.
REQ-016 I-format encoding SHALL be {imm[11:0], rs1, func3, rd, opcode}.
REQ-017 S-format encoding SHALL be {imm[11:5], rs2, rs1, func3, imm[4:0], opcode}.
REQ-018 B-format encoding SHALL be {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode}.
REQ-019 For I and S formats, an immediate whose imm[31:11] bits are not all equal SHALL set err.
REQ-020 For B format, an immediate whose imm[31:12] bits are not all equal, or with imm[0]=1, SHALL set err.
REQ-021 A word that sets err SHALL still be written, using truncated fields.
REQ-022 err SHALL stay set until the next accepted start or reset.
REQ-023 Field inputs SHALL be don't-care when in_valid=0.

Reset
REQ-024 While rst=0, the block SHALL hold state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0 and word_cnt=0.
REQ-025 Reset asserted mid-session SHALL abort the session with no further writes; after rst rises, the block SHALL wait in IDLE for a new start.

Verification
REQ-026 The bench SHALL cover a mixed-format session:
- stimulus: start with base_addr=0x100 and len=4, then one word per cycle:
  - R: opcode=0x33, rd=3, rs1=1, rs2=2, func3=0, func7=0.
  - I: opcode=0x13, rd=1, rs1=0, imm=5.
  - S: opcode=0x23, rs1=1, rs2=2, func3=2, imm=8.
  - B: opcode=0x63, rs1=0, rs2=0, func3=0, imm=-4.
- response: writes 0x002081B3@0x100, 0x00500093@0x104, 0x0020A423@0x108, 0xFE000EE3@0x10C; done=1 with the last write; word_cnt=4; err=0.
REQ-027 The bench SHALL cover a zero-length session: start with len=0 -> done=1 one cycle later, no mem_we, then IDLE.
REQ-028 The bench SHALL cover range errors:
- I-format imm=0x800 -> word written and err=1.
- B-format imm=3 -> err=1.
- next start -> err=0.
REQ-029 The bench SHALL cover gaps and ignored starts: in_valid gaps of 0-3 cycles with len=3 -> exactly 3 writes at consecutive addresses; a start pulse during LOAD has no effect.
REQ-030 The bench SHALL cover wrap and abort:
- base_addr=0xFFFFFFFC, len=2 -> writes at 0xFFFFFFFC then 0x00000000.
- rst=0 after the first accept -> all outputs reset immediately and no second write.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// Load-session bus: session control, instruction fields in, encoded memory writes out.
// The master drives the session and the fields; the slave is the loader.
interface instr_encoder_loader_if;
  logic        start;
  logic [31:0] base_addr;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] imm;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  word_cnt;

  modport master (
    output start, base_addr, len, in_valid, fmt, opcode, rd, rs1, rs2, func3, func7, imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, word_cnt
  );

  modport slave (
    input  start, base_addr, len, in_valid, fmt, opcode, rd, rs1, rs2, func3, func7, imm,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, word_cnt
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes R/I/S/B instruction fields into 32-bit words and writes a session of
// len words to consecutive instruction-memory addresses, one cycle after accept.
module instr_encoder_loader (
  input  logic                   clk,
  input  logic                   rst,
  instr_encoder_loader_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        last_word;
  logic [7:0]  len_q;
  logic [31:0] next_addr_q;
  logic        vld_p1;
  logic [31:0] addr_p1;
  logic [31:0] wdata_p1;
  logic        err_p1;
  logic [7:0]  cnt_p1;

  function automatic logic [31:0] encode_word(
    input logic [1:0]  fmt,
    input logic [6:0]  opcode,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  func3,
    input logic [6:0]  func7,
    input logic [31:0] imm
  );
    case (fmt)
      2'b00:   encode_word = {func7, rs2, rs1, func3, rd, opcode};
      2'b01:   encode_word = {imm[11:0], rs1, func3, rd, opcode};
      2'b10:   encode_word = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
      default: encode_word = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
    endcase
  endfunction

  // A signed range test is equivalent to the upper immediate bits all matching the sign.
  function automatic logic imm_range_err(
    input logic [1:0]         fmt,
    input logic signed [31:0] imm
  );
    case (fmt)
      2'b01, 2'b10: imm_range_err = (imm < -32'sd2048) || (imm > 32'sd2047);
      2'b11:        imm_range_err = (imm < -32'sd4096) || (imm > 32'sd4095) || imm[0];
      default:      imm_range_err = 1'b0;
    endcase
  endfunction

  assign accept    = bus.in_valid && (state == LOAD);
  assign last_word = ((cnt_p1 + 8'd1) == len_q);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = (bus.len == 8'd0) ? DONE : LOAD;
      end
      LOAD: begin
        if (accept && last_word) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Session length and write pointer only matter between a start and the words it covers.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      len_q       <= bus.len;
      next_addr_q <= bus.base_addr;
    end else if (accept) begin
      next_addr_q <= next_addr_q + 32'd4;
    end
  end

  // p0 -> p1: accepted fields become the registered memory write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
      err_p1   <= 1'b0;
      cnt_p1   <= '0;
    end else begin
      vld_p1 <= accept;
      if (state == IDLE && bus.start) begin
        err_p1 <= 1'b0;
        cnt_p1 <= '0;
      end
      if (accept) begin
        addr_p1  <= next_addr_q;
        wdata_p1 <= encode_word(bus.fmt, bus.opcode, bus.rd, bus.rs1, bus.rs2,
                                bus.func3, bus.func7, bus.imm);
        cnt_p1   <= cnt_p1 + 8'd1;
        if (imm_range_err(bus.fmt, bus.imm)) err_p1 <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = (state == LOAD);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.mem_we    = vld_p1;
  assign bus.mem_addr  = addr_p1;
  assign bus.mem_wdata = wdata_p1;
  assign bus.err       = err_p1;
  assign bus.word_cnt  = cnt_p1;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: single-word vector table plus
// hand-written multi-cycle sessions (mixed, zero-length, errors, gaps, wrap, abort).
module tb_instr_encoder_loader;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   wr_cnt;
  int   wr0;

  instr_encoder_loader_if bus();

  instr_encoder_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.mem_we === 1'b1) wr_cnt++;

  typedef struct {
    logic [1:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] word;
    logic        err;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [1:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] imm);
    bus.fmt = fmt; bus.opcode = op; bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2;
    bus.func3 = f3; bus.func7 = f7; bus.imm = imm;
    bus.in_valid = 1'b1;
  endtask

  task automatic start_session(input logic [31:0] base, input logic [7:0] n);
    bus.start = 1'b1; bus.base_addr = base; bus.len = n;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic accept_word();
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready never rose within 20 cycles at %0t", $time);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_write(input string name, input logic [31:0] addr, input logic [31:0] data);
    chk({name, ".mem_we"},    32'(bus.mem_we), 32'd1);
    chk({name, ".mem_addr"},  bus.mem_addr, addr);
    chk({name, ".mem_wdata"}, bus.mem_wdata, data);
  endtask

  initial begin
    total = 0; bad = 0; wr_cnt = 0;
    vecs[0]  = '{2'b00, 7'h7F, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h12345678, 32'hFFFFFFFF, 1'b0};
    vecs[1]  = '{2'b01, 7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFFFFFF, 32'hFFF00093, 1'b0};
    vecs[2]  = '{2'b01, 7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'h000007FF, 32'h7FF00093, 1'b0};
    vecs[3]  = '{2'b01, 7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFFF800, 32'h80000093, 1'b0};
    vecs[4]  = '{2'b01, 7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000800, 32'h80000093, 1'b1};
    vecs[5]  = '{2'b10, 7'h23, 5'd0,  5'd1,  5'd2,  3'd2, 7'h00, 32'hFFFFFFFF, 32'hFE20AFA3, 1'b0};
    vecs[6]  = '{2'b10, 7'h23, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000800, 32'h80000023, 1'b1};
    vecs[7]  = '{2'b11, 7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000FFE, 32'h7E000FE3, 1'b0};
    vecs[8]  = '{2'b11, 7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00001000, 32'h80000063, 1'b1};
    vecs[9]  = '{2'b11, 7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000003, 32'h00000163, 1'b1};
    vecs[10] = '{2'b01, 7'h03, 5'd5,  5'd2,  5'd0,  3'd2, 7'h00, 32'hFFFFFFF0, 32'hFF012283, 1'b0};

    rst = 1'b0;
    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.in_valid = 1'b0;
    bus.fmt = '0; bus.opcode = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0;
    bus.func3 = '0; bus.func7 = '0; bus.imm = '0;
    repeat (2) tick();
    chk("rst.mem_we",    32'(bus.mem_we), 32'd0);
    chk("rst.mem_addr",  bus.mem_addr, 32'd0);
    chk("rst.mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst.in_ready",  32'(bus.in_ready), 32'd0);
    chk("rst.busy",      32'(bus.busy), 32'd0);
    chk("rst.done",      32'(bus.done), 32'd0);
    chk("rst.err",       32'(bus.err), 32'd0);
    chk("rst.word_cnt",  32'(bus.word_cnt), 32'd0);
    rst = 1'b1;
    tick();

    // Mixed-format session
    start_session(32'h100, 8'd4);
    chk("mix.in_ready", 32'(bus.in_ready), 32'd1);
    chk("mix.busy",     32'(bus.busy), 32'd1);
    set_word(2'b00, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    accept_word();
    check_write("mix.R", 32'h100, 32'h002081B3);
    chk("mix.R.done", 32'(bus.done), 32'd0);
    set_word(2'b01, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    accept_word();
    check_write("mix.I", 32'h104, 32'h00500093);
    set_word(2'b10, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    accept_word();
    check_write("mix.S", 32'h108, 32'h0020A423);
    set_word(2'b11, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC);
    accept_word();
    check_write("mix.B", 32'h10C, 32'hFE000EE3);
    chk("mix.done",     32'(bus.done), 32'd1);
    chk("mix.word_cnt", 32'(bus.word_cnt), 32'd4);
    chk("mix.err",      32'(bus.err), 32'd0);
    tick();
    chk("mix.idle.done",   32'(bus.done), 32'd0);
    chk("mix.idle.busy",   32'(bus.busy), 32'd0);
    chk("mix.idle.mem_we", 32'(bus.mem_we), 32'd0);

    // Single-word sessions from the vector table
    for (int i = 0; i < 11; i++) begin
      start_session(32'(32'h1000 + i * 16), 8'd1);
      set_word(vecs[i].fmt, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
               vecs[i].f3, vecs[i].f7, vecs[i].imm);
      accept_word();
      check_write($sformatf("vec%0d", i), 32'(32'h1000 + i * 16), vecs[i].word);
      chk($sformatf("vec%0d.err", i),  32'(bus.err), 32'(vecs[i].err));
      chk($sformatf("vec%0d.done", i), 32'(bus.done), 32'd1);
      tick();
    end

    // Range errors are sticky until the next start
    start_session(32'h300, 8'd2);
    set_word(2'b01, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
    accept_word();
    check_write("rerr.I", 32'h300, 32'h80000093);
    chk("rerr.I.err", 32'(bus.err), 32'd1);
    set_word(2'b11, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    accept_word();
    check_write("rerr.B", 32'h304, 32'h00000163);
    chk("rerr.B.err", 32'(bus.err), 32'd1);
    tick();
    chk("rerr.sticky", 32'(bus.err), 32'd1);
    start_session(32'h400, 8'd1);
    chk("rerr.cleared", 32'(bus.err), 32'd0);
    chk("rerr.cnt_cleared", 32'(bus.word_cnt), 32'd0);
    set_word(2'b01, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    accept_word();
    check_write("rerr.ok", 32'h400, 32'h00500093);
    chk("rerr.ok.err", 32'(bus.err), 32'd0);
    tick();

    // Zero-length session
    wr0 = wr_cnt;
    start_session(32'h500, 8'd0);
    chk("zero.done",     32'(bus.done), 32'd1);
    chk("zero.busy",     32'(bus.busy), 32'd1);
    chk("zero.in_ready", 32'(bus.in_ready), 32'd0);
    chk("zero.mem_we",   32'(bus.mem_we), 32'd0);
    tick();
    chk("zero.idle.done", 32'(bus.done), 32'd0);
    chk("zero.idle.busy", 32'(bus.busy), 32'd0);
    chk("zero.writes",    32'(wr_cnt - wr0), 32'd0);

    // Gaps between words and a start pulse during LOAD
    wr0 = wr_cnt;
    start_session(32'h200, 8'd3);
    for (int k = 0; k < 3; k++) begin
      for (int g = 0; g < (k == 0 ? 0 : (k == 1 ? 3 : 2)); g++) begin
        bus.in_valid = 1'b0;
        if (k == 1 && g == 1) begin
          bus.start = 1'b1; bus.base_addr = 32'h900; bus.len = 8'd7;
        end
        tick();
        bus.start = 1'b0;
        chk($sformatf("gap%0d.%0d.mem_we", k, g), 32'(bus.mem_we), 32'd0);
      end
      set_word(2'b00, 7'h33, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      accept_word();
      check_write($sformatf("gap.w%0d", k), 32'(32'h200 + 4 * k), 32'(32'h33 + (k << 7)));
    end
    chk("gap.done",     32'(bus.done), 32'd1);
    chk("gap.word_cnt", 32'(bus.word_cnt), 32'd3);
    tick();
    chk("gap.idle.busy", 32'(bus.busy), 32'd0);
    chk("gap.writes",    32'(wr_cnt - wr0), 32'd3);
    tick();
    chk("gap.no_restart", 32'(bus.busy), 32'd0);

    // Address wrap
    start_session(32'hFFFFFFFC, 8'd2);
    set_word(2'b01, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    accept_word();
    check_write("wrap.w0", 32'hFFFFFFFC, 32'h00500093);
    set_word(2'b01, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    accept_word();
    check_write("wrap.w1", 32'h00000000, 32'h00500113);
    chk("wrap.done", 32'(bus.done), 32'd1);
    tick();

    // Reset mid-session
    start_session(32'hFFFFFFFC, 8'd2);
    set_word(2'b01, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
    accept_word();
    check_write("abort.w0", 32'hFFFFFFFC, 32'h80000093);
    chk("abort.w0.err", 32'(bus.err), 32'd1);
    wr0 = wr_cnt;
    #1 rst = 1'b0;
    #1;
    chk("abort.mem_we",    32'(bus.mem_we), 32'd0);
    chk("abort.mem_addr",  bus.mem_addr, 32'd0);
    chk("abort.mem_wdata", bus.mem_wdata, 32'd0);
    chk("abort.busy",      32'(bus.busy), 32'd0);
    chk("abort.done",      32'(bus.done), 32'd0);
    chk("abort.in_ready",  32'(bus.in_ready), 32'd0);
    chk("abort.err",       32'(bus.err), 32'd0);
    chk("abort.word_cnt",  32'(bus.word_cnt), 32'd0);
    set_word(2'b01, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("abort.idle.in_ready", 32'(bus.in_ready), 32'd0);
    chk("abort.idle.busy",     32'(bus.busy), 32'd0);
    chk("abort.idle.mem_we",   32'(bus.mem_we), 32'd0);
    chk("abort.writes",        32'(wr_cnt - wr0), 32'd0);
    bus.in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
